dmem_write_scoreboard: RTL and testbench

Synthesizable self-check monitor for the processor system. It watches the data-memory write port and compares each write against a programmable table of expected (address, data) entries. It also counts run cycles and checks the final ALU result at a programmed cycle limit. Results are reported as pass/fail/unexpected/missing counters plus summary flags, so the same check runs in simulation or on an FPGA debug build.

---
 rtl/dmem_write_scoreboard.sv | 167 ++++++++++++++++
 tb/tb_dmem_write_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_scoreboard.sv
// Self-check monitor: scores data-memory writes against a programmable table of
// expected (address, data) entries and checks the ALU result at a programmed cycle limit.
module dmem_write_scoreboard #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 8,
    parameter int CYCLE_W = 16,
    parameter int CNT_W   = 8,
    parameter bit ORDERED = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    input  logic                     cfg_clear,
    input  logic [CYCLE_W-1:0]       max_cycles,
    input  logic [DATA_W-1:0]        final_expected,
    input  logic                     start,
    input  logic                     mon_we,
    input  logic [ADDR_W-1:0]        mon_addr,
    input  logic [DATA_W-1:0]        mon_wd,
    input  logic [DATA_W-1:0]        mon_alu,
    output logic [CYCLE_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic [CNT_W-1:0]         unexpected_count,
    output logic [CNT_W-1:0]         missing_count,
    output logic                     final_ok,
    output logic                     all_ok,
    output logic                     busy,
    output logic                     done
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t             state_reg;
    logic [DEPTH-1:0]   valid_reg;
    logic [DEPTH-1:0]   hit_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    logic               cfg_ok;
    logic [DEPTH-1:0]   addr_hit_vec;
    logic [DEPTH-1:0]   avail_vec;
    logic [DEPTH-1:0]   sel_vec;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               match_ok;
    logic [PTR_W-1:0]   pending_cnt;
    logic [CNT_W-1:0]   missing_next;

    assign cfg_ok = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign busy   = (state_reg == S_RUN) || (state_reg == S_CHECK);
    assign done   = (state_reg == S_DONE);

    // Per-entry candidates: address hit for unordered mode, valid-at-or-after-pointer for ordered mode.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] ENTRY_IDX = PTR_W'(gi);
            assign addr_hit_vec[gi] = valid_reg[gi] && !hit_reg[gi] && (addr_mem[gi] == mon_addr);
            assign avail_vec[gi]    = valid_reg[gi] && (ENTRY_IDX >= ptr_reg);
        end
    endgenerate

    assign sel_vec = ORDERED ? avail_vec : addr_hit_vec;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign match_ok = ORDERED ? ((addr_mem[sel_idx] == mon_addr) && (data_mem[sel_idx] == mon_wd))
                              : (data_mem[sel_idx] == mon_wd);

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_cnt = pending_cnt + PTR_W'(valid_reg[i] & ~hit_reg[i]);
        end
    end

    assign missing_next = (32'(pending_cnt) > 32'((1 << CNT_W) - 1)) ? '1 : CNT_W'(pending_cnt);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (cfg_ok && cfg_we && !cfg_clear) begin
            addr_mem[cfg_idx] <= cfg_addr;
            data_mem[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            valid_reg        <= '0;
            hit_reg          <= '0;
            ptr_reg          <= '0;
            cycle_count      <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            unexpected_count <= '0;
            missing_count    <= '0;
            final_ok         <= 1'b0;
            all_ok           <= 1'b0;
        end else begin
            if (cfg_ok) begin
                if (cfg_clear)   valid_reg          <= '0;
                else if (cfg_we) valid_reg[cfg_idx] <= 1'b1;
            end
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg        <= S_RUN;
                        hit_reg          <= '0;
                        ptr_reg          <= '0;
                        cycle_count      <= '0;
                        pass_count       <= '0;
                        fail_count       <= '0;
                        unexpected_count <= '0;
                        missing_count    <= '0;
                        final_ok         <= 1'b0;
                        all_ok           <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (mon_we) begin
                        if (sel_found) begin
                            hit_reg[sel_idx] <= 1'b1;
                            if (match_ok) pass_count <= sat_inc(pass_count);
                            else          fail_count <= sat_inc(fail_count);
                            if (ORDERED)  ptr_reg    <= {1'b0, sel_idx} + 1'b1;
                        end else begin
                            unexpected_count <= sat_inc(unexpected_count);
                        end
                    end
                    if (cycle_count >= max_cycles) begin
                        final_ok  <= (mon_alu == final_expected);
                        state_reg <= S_CHECK;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_CHECK: begin
                    missing_count <= missing_next;
                    all_ok        <= final_ok && (fail_count == '0) && (unexpected_count == '0)
                                     && (missing_next == '0);
                    state_reg     <= S_DONE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_write_scoreboard.sv
// Directed bench: an unordered and an ordered scoreboard watch the same write stream.
module tb_dmem_write_scoreboard;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0, cfg_clear = 1'b0, start = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [9:0]  cfg_addr = '0, mon_addr = '0;
    logic [31:0] cfg_data = '0, final_expected = '0, mon_wd = '0, mon_alu = '0;
    logic [15:0] max_cycles = '0;
    logic        mon_we = 1'b0;

    logic [15:0] cycle_count, cycle_count_o;
    logic [7:0]  pass_count, fail_count, unexpected_count, missing_count;
    logic [7:0]  pass_count_o, fail_count_o, unexpected_count_o, missing_count_o;
    logic        final_ok, all_ok, busy, done;
    logic        final_ok_o, all_ok_o, busy_o, done_o;

    int total = 0;
    int bad = 0;
    int nw = 0;
    int dist_cycle = -1;
    int clr_cycle = -1;
    int          wc [16];
    logic [9:0]  wa [16];
    logic [31:0] wd [16];
    logic [9:0]  ta [8];
    logic [31:0] td [8];

    always #5 clock = ~clock;

    dmem_write_scoreboard #(.ORDERED(1'b0)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_clear(cfg_clear), .max_cycles(max_cycles),
        .final_expected(final_expected), .start(start), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_wd(mon_wd), .mon_alu(mon_alu), .cycle_count(cycle_count), .pass_count(pass_count),
        .fail_count(fail_count), .unexpected_count(unexpected_count), .missing_count(missing_count),
        .final_ok(final_ok), .all_ok(all_ok), .busy(busy), .done(done));

    dmem_write_scoreboard #(.ORDERED(1'b1)) dut_o (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_clear(cfg_clear), .max_cycles(max_cycles),
        .final_expected(final_expected), .start(start), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_wd(mon_wd), .mon_alu(mon_alu), .cycle_count(cycle_count_o), .pass_count(pass_count_o),
        .fail_count(fail_count_o), .unexpected_count(unexpected_count_o),
        .missing_count(missing_count_o), .final_ok(final_ok_o), .all_ok(all_ok_o),
        .busy(busy_o), .done(done_o));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic res(input string tag, input logic [7:0] pc, fc, uc, mc, input logic fo, ao,
                       input int ep, ef, eu, em, input logic efo, eao);
        $display("run %s: pass=%0d fail=%0d unexp=%0d miss=%0d final_ok=%0b all_ok=%0b",
                 tag, pc, fc, uc, mc, fo, ao);
        chk({tag, ".pass"}, 32'(pc), 32'(ep));
        chk({tag, ".fail"}, 32'(fc), 32'(ef));
        chk({tag, ".unexp"}, 32'(uc), 32'(eu));
        chk({tag, ".miss"}, 32'(mc), 32'(em));
        chk({tag, ".final_ok"}, 32'(fo), 32'(efo));
        chk({tag, ".all_ok"}, 32'(ao), 32'(eao));
    endtask

    task automatic load_table();
        @(negedge clock) cfg_clear = 1'b1;
        @(negedge clock) cfg_clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = ta[i]; cfg_data = td[i];
            @(negedge clock);
        end
        cfg_we = 1'b0;
    endtask

    task automatic writes_in_order(input int n);
        nw = n;
        for (int i = 0; i < n; i++) begin
            wc[i] = 4 + 8 * i; wa[i] = ta[i]; wd[i] = td[i];
        end
    endtask

    task automatic idle_inputs();
        mon_we = 1'b0; mon_addr = '0; mon_wd = '0; mon_alu = '0;
        cfg_we = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    endtask

    // Every iteration lands on the negedge inside RUN cycle k; fixed length, so it always terminates.
    task automatic do_run(input logic [31:0] alu_final, input bit flood, input int abort_at);
        @(negedge clock) start = 1'b1; mon_we = 1'b0;
        for (int k = 0; k <= int'(max_cycles); k++) begin
            @(negedge clock);
            idle_inputs();
            if (k == 0) begin
                chk("first_cycle_count", 32'(cycle_count), 0);
                chk("first_pass_cleared", 32'(pass_count), 0);
            end
            if (k == int'(max_cycles)) begin
                chk("last_cycle_count", 32'(cycle_count), 32'(max_cycles));
                chk("last_done_low", 32'(done), 0);
            end
            if (k == abort_at) begin
                chk("pre_abort_pass", 32'(pass_count), 2);
                reset = 1'b1;
                #1;
                chk("abort_cycle_count", 32'(cycle_count), 0);
                chk("abort_pass", 32'(pass_count), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_ord_pass", 32'(pass_count_o), 0);
                @(negedge clock) reset = 1'b0;
                return;
            end
            for (int i = 0; i < nw; i++) begin
                if (wc[i] == k) begin
                    mon_we = 1'b1; mon_addr = wa[i]; mon_wd = wd[i];
                end
            end
            if (flood) begin
                mon_we = 1'b1; mon_addr = 10'h3FF; mon_wd = 32'(k);
            end
            if (k == int'(max_cycles)) mon_alu = alu_final;
            if (k == dist_cycle) begin
                cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 10'h1FC; cfg_data = 32'h99; start = 1'b1;
            end
            if (k == clr_cycle) cfg_clear = 1'b1;
        end
        @(negedge clock);
        idle_inputs();
        chk("check_busy", 32'(busy), 1);
        chk("check_done_low", 32'(done), 0);
        @(negedge clock);
        chk("done_high", 32'(done), 1);
        chk("done_cycle_hold", 32'(cycle_count), 32'(max_cycles));
    endtask

    initial begin
        ta = '{10'h1FC, 10'h1F8, 10'h1F4, 10'h1F0, 10'h1EC, 10'h1E8, 10'h1E4, 10'h1E0};
        td = '{32'h4, 32'h8, 32'h3, 32'h3C, 32'h2, 32'h3C, 32'h1, 32'h3C};

        repeat (3) @(negedge clock);
        chk("rst_cycle_count", 32'(cycle_count), 0);
        chk("rst_pass", 32'(pass_count), 0);
        chk("rst_unexp", 32'(unexpected_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_all_ok", 32'(all_ok), 0);
        reset = 1'b0;

        max_cycles = 16'd106;
        final_expected = 32'h18;
        load_table();

        writes_in_order(8);
        do_run(32'h18, 1'b0, -1);
        res("t1", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 8, 0, 0, 0, 1, 1);
        res("t1o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 8, 0, 0, 0, 1, 1);

        writes_in_order(8);
        wd[2] = 32'h5;
        do_run(32'h18, 1'b0, -1);
        res("t2", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 7, 1, 0, 0, 1, 0);
        res("t2o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 7, 1, 0, 0, 1, 0);

        nw = 8;
        for (int i = 0; i < 8; i++) begin
            wc[i] = 4 + 8 * i; wa[i] = ta[7 - i]; wd[i] = td[7 - i];
        end
        do_run(32'h18, 1'b0, -1);
        res("t3", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 8, 0, 0, 0, 1, 1);
        res("t3o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 0, 8, 0, 0, 1, 0);

        writes_in_order(8);
        wc[8] = 68; wa[8] = 10'h100; wd[8] = 32'h0;
        wc[9] = 76; wa[9] = 10'h1FC; wd[9] = 32'h4;
        nw = 10;
        do_run(32'h18, 1'b0, -1);
        res("t4", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 8, 0, 2, 0, 1, 0);
        res("t4o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 8, 0, 2, 0, 1, 0);

        writes_in_order(6);
        do_run(32'h17, 1'b0, -1);
        res("t5", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 6, 0, 0, 2, 0, 0);
        res("t5o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 6, 0, 0, 2, 0, 0);

        // Reset mid-run wipes the table, so the rerun sees only unexpected writes.
        writes_in_order(8);
        do_run(32'h18, 1'b0, 20);
        do_run(32'h18, 1'b0, -1);
        res("t6a", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 0, 0, 8, 0, 1, 0);
        res("t6ao", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 0, 0, 8, 0, 1, 0);

        load_table();
        writes_in_order(8);
        dist_cycle = 2;
        clr_cycle = 50;
        do_run(32'h18, 1'b0, -1);
        dist_cycle = -1;
        clr_cycle = -1;
        res("t6b", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 8, 0, 0, 0, 1, 1);
        res("t6bo", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 8, 0, 0, 0, 1, 1);

        // Clear beats a simultaneous entry write; one-cycle run with max_cycles = 0.
        @(negedge clock);
        cfg_clear = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 10'h1FC; cfg_data = 32'h4;
        @(negedge clock);
        cfg_clear = 1'b0; cfg_we = 1'b0;
        max_cycles = 16'd0;
        nw = 1; wc[0] = 0; wa[0] = 10'h1FC; wd[0] = 32'h4;
        do_run(32'h18, 1'b0, -1);
        res("t7", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 0, 0, 1, 0, 1, 0);
        res("t7o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 0, 0, 1, 0, 1, 0);

        // 300 unmatched writes saturate the 8-bit counter.
        max_cycles = 16'd299;
        nw = 0;
        do_run(32'h18, 1'b1, -1);
        res("t8", pass_count, fail_count, unexpected_count, missing_count, final_ok, all_ok, 0, 0, 255, 0, 1, 0);
        res("t8o", pass_count_o, fail_count_o, unexpected_count_o, missing_count_o, final_ok_o, all_ok_o, 0, 0, 255, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
